tone_cfg_shadow_commit: RTL and testbench



---
 rtl/tone_cfg_shadow_commit_if.sv | 18 +
 rtl/tone_cfg_shadow_commit.sv | 217 +++++++++++++++++++++
 tb/tb_tone_cfg_shadow_commit.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_cfg_shadow_commit_if.sv
// Command bus into the tone configuration sink.
// Handshake: gpio_wen is a valid strobe with no ready. The sink takes one
// command word from gpio_wdata in every cycle where gpio_wen is high, so the
// master never waits and never has to hold a word for more than one cycle.
interface tone_cfg_shadow_commit_if;
  logic        gpio_wen;
  logic [31:0] gpio_wdata;

  modport master (
    output gpio_wen,
    output gpio_wdata
  );

  modport slave (
    input gpio_wen,
    input gpio_wdata
  );
endinterface

// File: rtl/tone_cfg_shadow_commit.sv
// Tone configuration command sink.
// INDEX/GAIN commands land in a per-channel, per-tone shadow set. A COMMIT
// arms a two-state FSM. The whole shadow set is copied into the active set at
// the first edge where commit_safe is high, so the tone generators never see
// a half-updated configuration.
module tone_cfg_shadow_commit #(
  parameter int IDX_W  = 10,
  parameter int GAIN_W = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  tone_cfg_shadow_commit_if.slave cmd_if,
  input  logic                    commit_safe,
  output logic [8*IDX_W-1:0]      idx_a_flat,
  output logic [8*GAIN_W-1:0]     gain_a_flat,
  output logic [8*IDX_W-1:0]      idx_b_flat,
  output logic [8*GAIN_W-1:0]     gain_b_flat,
  output logic                    commit_pulse,
  output logic                    commit_pending,
  output logic                    shadow_dirty,
  output logic                    cmd_err,
  output logic [7:0]              err_cnt,
  output logic                    state_dbg
);

  localparam logic [3:0] CMD_CLR_ERR = 4'h0;
  localparam logic [3:0] CMD_INDEX   = 4'h1;
  localparam logic [3:0] CMD_GAIN    = 4'h2;
  localparam logic [3:0] CMD_COMMIT  = 4'hF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Command word fields
  logic [3:0]  f_cmd;
  logic        f_ch;
  logic [2:0]  f_tone;
  logic [3:0]  f_rsv;
  logic [19:0] f_data;

  assign f_cmd  = cmd_if.gpio_wdata[31:28];
  assign f_ch   = cmd_if.gpio_wdata[27];
  assign f_tone = cmd_if.gpio_wdata[26:24];
  assign f_rsv  = cmd_if.gpio_wdata[23:20];
  assign f_data = cmd_if.gpio_wdata[19:0];

  // Decode: each command is either accepted (exactly one of the *_acc
  // strobes) or rejected; a rejected command only touches the error state.
  logic idx_over;
  logic gain_over;
  logic idx_acc;
  logic gain_acc;
  logic commit_acc;
  logic clr_acc;
  logic cmd_rej;

  assign idx_over  = |(f_data >> IDX_W);
  assign gain_over = |(f_data >> GAIN_W);

  // Classify the strobed command
  always_comb begin
    idx_acc    = 1'b0;
    gain_acc   = 1'b0;
    commit_acc = 1'b0;
    clr_acc    = 1'b0;
    cmd_rej    = 1'b0;
    if (cmd_if.gpio_wen) begin
      unique case (f_cmd)
        CMD_CLR_ERR: begin
          if (f_data == '0) clr_acc = 1'b1;
          else              cmd_rej = 1'b1;
        end
        CMD_INDEX: begin
          if (f_rsv == '0 && !idx_over) idx_acc = 1'b1;
          else                          cmd_rej = 1'b1;
        end
        CMD_GAIN: begin
          if (f_rsv == '0 && !gain_over) gain_acc = 1'b1;
          else                           cmd_rej  = 1'b1;
        end
        CMD_COMMIT: commit_acc = 1'b1;
        default:    cmd_rej    = 1'b1;
      endcase
    end
  end

  // Commit FSM: state and its registered outputs
  state_t state_q, state_d;
  logic   commit_pulse_q, commit_pulse_d;
  logic   commit_pending_q, commit_pending_d;
  logic   apply;

  // The apply edge is any edge spent in S_WAIT with commit_safe high.
  assign apply = (state_q == S_WAIT) && commit_safe;

  // Next state: a COMMIT arriving on the apply edge re-arms the FSM, so the
  // writes that raced the apply get their own copy at the next safe edge.
  always_comb begin
    state_d        = state_q;
    commit_pulse_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (commit_acc) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (commit_safe) begin
          commit_pulse_d = 1'b1;
          state_d        = commit_acc ? S_WAIT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    commit_pending_d = (state_d == S_WAIT);
  end

  // FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      commit_pulse_q   <= 1'b0;
      commit_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      commit_pulse_q   <= commit_pulse_d;
      commit_pending_q <= commit_pending_d;
    end
  end

  // Shadow and active register sets, indexed [channel][tone]
  logic [1:0][7:0][IDX_W-1:0]  shadow_idx_q, shadow_idx_d;
  logic [1:0][7:0][GAIN_W-1:0] shadow_gain_q, shadow_gain_d;
  logic [1:0][7:0][IDX_W-1:0]  active_idx_q, active_idx_d;
  logic [1:0][7:0][GAIN_W-1:0] active_gain_q, active_gain_d;
  logic                        shadow_dirty_q, shadow_dirty_d;

  // Shadow writes and the atomic copy; the copy reads the current shadow, so
  // a write landing on the apply edge is not part of that apply.
  always_comb begin
    shadow_idx_d   = shadow_idx_q;
    shadow_gain_d  = shadow_gain_q;
    active_idx_d   = active_idx_q;
    active_gain_d  = active_gain_q;
    shadow_dirty_d = shadow_dirty_q;
    if (apply) begin
      active_idx_d   = shadow_idx_q;
      active_gain_d  = shadow_gain_q;
      shadow_dirty_d = 1'b0;
    end
    if (idx_acc) begin
      shadow_idx_d[f_ch][f_tone] = f_data[IDX_W-1:0];
      shadow_dirty_d             = 1'b1;
    end
    if (gain_acc) begin
      shadow_gain_d[f_ch][f_tone] = f_data[GAIN_W-1:0];
      shadow_dirty_d              = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_idx_q   <= '0;
      shadow_gain_q  <= '0;
      active_idx_q   <= '0;
      active_gain_q  <= '0;
      shadow_dirty_q <= 1'b0;
    end else begin
      shadow_idx_q   <= shadow_idx_d;
      shadow_gain_q  <= shadow_gain_d;
      active_idx_q   <= active_idx_d;
      active_gain_q  <= active_gain_d;
      shadow_dirty_q <= shadow_dirty_d;
    end
  end

  // Error bookkeeping
  logic       cmd_err_q, cmd_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Sticky flag plus saturating count; CLR_ERR wipes both
  always_comb begin
    cmd_err_d = cmd_err_q;
    err_cnt_d = err_cnt_q;
    if (cmd_rej) begin
      cmd_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (clr_acc) begin
      cmd_err_d = 1'b0;
      err_cnt_d = 8'd0;
    end
  end

  // Error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      cmd_err_q <= cmd_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign idx_a_flat     = active_idx_q[0];
  assign gain_a_flat    = active_gain_q[0];
  assign idx_b_flat     = active_idx_q[1];
  assign gain_b_flat    = active_gain_q[1];
  assign commit_pulse   = commit_pulse_q;
  assign commit_pending = commit_pending_q;
  assign shadow_dirty   = shadow_dirty_q;
  assign cmd_err        = cmd_err_q;
  assign err_cnt        = err_cnt_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_tone_cfg_shadow_commit.sv
// Bench for tone_cfg_shadow_commit: directed scenarios plus a random command
// stream, checked every cycle against a behavioural model.
module tb_tone_cfg_shadow_commit;
  localparam int IDX_W  = 10;
  localparam int GAIN_W = 18;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic commit_safe = 1'b0;
  always #5 clk = ~clk;

  tone_cfg_shadow_commit_if bus ();

  logic [8*IDX_W-1:0]  idx_a_flat, idx_b_flat;
  logic [8*GAIN_W-1:0] gain_a_flat, gain_b_flat;
  logic                commit_pulse, commit_pending, shadow_dirty, cmd_err, state_dbg;
  logic [7:0]          err_cnt;

  tone_cfg_shadow_commit #(.IDX_W(IDX_W), .GAIN_W(GAIN_W)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_if(bus.slave),
    .commit_safe(commit_safe),
    .idx_a_flat(idx_a_flat),
    .gain_a_flat(gain_a_flat),
    .idx_b_flat(idx_b_flat),
    .gain_b_flat(gain_b_flat),
    .commit_pulse(commit_pulse),
    .commit_pending(commit_pending),
    .shadow_dirty(shadow_dirty),
    .cmd_err(cmd_err),
    .err_cnt(err_cnt),
    .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain arrays and flags following the command rules
  int unsigned m_sh_idx[2][8], m_sh_gain[2][8], m_act_idx[2][8], m_act_gain[2][8];
  bit m_pending, m_dirty, m_err, m_pulse;
  int m_cnt;

  function automatic bit cmd_ok(input logic [31:0] w);
    int unsigned d;
    d = w[19:0];
    case (w[31:28])
      4'h0:    return d == 0;
      4'h1:    return w[23:20] == 0 && d < (1 << IDX_W);
      4'h2:    return w[23:20] == 0 && d < (1 << GAIN_W);
      4'hF:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] w;
    bit apply;
    int c, t;
    if (rst) begin
      foreach (m_sh_idx[i, j]) begin
        m_sh_idx[i][j] = 0; m_sh_gain[i][j] = 0;
        m_act_idx[i][j] = 0; m_act_gain[i][j] = 0;
      end
      m_pending = 0; m_dirty = 0; m_err = 0; m_pulse = 0; m_cnt = 0;
    end else begin
      w = bus.gpio_wdata;
      c = int'(w[27]);
      t = int'(w[26:24]);
      apply = m_pending && commit_safe;
      m_pulse = apply;
      if (apply) begin
        m_act_idx = m_sh_idx;
        m_act_gain = m_sh_gain;
        m_dirty = 0;
        m_pending = 0;
      end
      if (bus.gpio_wen) begin
        if (!cmd_ok(w)) begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
        end else if (w[31:28] == 4'h1) begin
          m_sh_idx[c][t] = w[19:0];
          m_dirty = 1;
        end else if (w[31:28] == 4'h2) begin
          m_sh_gain[c][t] = w[19:0];
          m_dirty = 1;
        end else if (w[31:28] == 4'hF) begin
          m_pending = 1;
        end else begin
          m_err = 0;
          m_cnt = 0;
        end
      end
    end
  end

  function automatic logic [8*IDX_W-1:0] exp_idx(input int ch);
    logic [8*IDX_W-1:0] r;
    for (int t = 0; t < 8; t++) r[t*IDX_W +: IDX_W] = m_act_idx[ch][t][IDX_W-1:0];
    return r;
  endfunction

  function automatic logic [8*GAIN_W-1:0] exp_gain(input int ch);
    logic [8*GAIN_W-1:0] r;
    for (int t = 0; t < 8; t++) r[t*GAIN_W +: GAIN_W] = m_act_gain[ch][t][GAIN_W-1:0];
    return r;
  endfunction

  // Compare process: every output against the model, every cycle after reset
  always @(negedge clk) begin
    if (chk_en) begin
      chk("idx_a", 144'(idx_a_flat), 144'(exp_idx(0)));
      chk("gain_a", 144'(gain_a_flat), 144'(exp_gain(0)));
      chk("idx_b", 144'(idx_b_flat), 144'(exp_idx(1)));
      chk("gain_b", 144'(gain_b_flat), 144'(exp_gain(1)));
      chk("pulse", 144'(commit_pulse), 144'(m_pulse));
      chk("pending", 144'(commit_pending), 144'(m_pending));
      chk("dirty", 144'(shadow_dirty), 144'(m_dirty));
      chk("cmd_err", 144'(cmd_err), 144'(m_err));
      chk("err_cnt", 144'(err_cnt), 144'(m_cnt));
    end
  end

  // Driver: inputs change at the negedge, the DUT samples them at the next posedge
  task automatic step(input logic wen, input logic [31:0] wd, input logic safe);
    bus.gpio_wen   = wen;
    bus.gpio_wdata = wd;
    commit_safe    = safe;
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic [3:0] cmd, input logic ch, input logic [2:0] tone,
                                     input logic [3:0] rsv, input logic [19:0] data);
    return {cmd, ch, tone, rsv, data};
  endfunction

  task automatic idle(input logic safe);
    step(1'b0, 32'h0, safe);
  endtask

  // Watchdog
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  int unsigned sw_idx[2][8], sw_gain[2][8];

  initial begin
    logic [31:0] w;
    int r;
    bus.gpio_wen = 1'b0;
    bus.gpio_wdata = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_idx_a", 144'(idx_a_flat), 144'd0);
    chk("reset_err_cnt", 144'(err_cnt), 144'd0);

    // Basic load and commit
    step(1'b1, mk(4'h1, 1'b0, 3'd3, 4'h0, 20'h155), 1'b0);
    step(1'b1, mk(4'h2, 1'b0, 3'd3, 4'h0, 20'h1FFFF), 1'b0);
    chk("basic_dirty_set", 144'(shadow_dirty), 144'd1);
    step(1'b1, mk(4'hF, 1'b0, 3'd0, 4'h0, 20'h0), 1'b1);
    chk("basic_pending", 144'(commit_pending), 144'd1);
    chk("basic_no_apply_yet", 144'(idx_a_flat[39:30]), 144'd0);
    idle(1'b1);
    chk("basic_idx_a3", 144'(idx_a_flat[39:30]), 144'h155);
    chk("basic_gain_a3", 144'(gain_a_flat[71:54]), 144'h1FFFF);
    chk("basic_pulse", 144'(commit_pulse), 144'd1);
    chk("basic_dirty_clr", 144'(shadow_dirty), 144'd0);
    chk("basic_pending_clr", 144'(commit_pending), 144'd0);
    idle(1'b1);
    chk("basic_pulse_once", 144'(commit_pulse), 144'd0);

    // Gated commit
    step(1'b1, mk(4'h1, 1'b1, 3'd0, 4'h0, 20'h3FF), 1'b0);
    step(1'b1, mk(4'hF, 1'b0, 3'd0, 4'h0, 20'h0), 1'b0);
    for (int i = 0; i < 20; i++) begin
      idle(1'b0);
      chk("gated_pending", 144'(commit_pending), 144'd1);
      chk("gated_idx_b", 144'(idx_b_flat), 144'd0);
    end
    idle(1'b1);
    chk("gated_apply", 144'(idx_b_flat[9:0]), 144'h3FF);
    chk("gated_pulse", 144'(commit_pulse), 144'd1);
    idle(1'b0);
    chk("gated_pulse_once", 144'(commit_pulse), 144'd0);

    // Boundary collisions
    step(1'b1, mk(4'hF, 1'b0, 3'd0, 4'h0, 20'h0), 1'b0);
    step(1'b1, mk(4'h2, 1'b1, 3'd7, 4'h0, 20'h0AAA), 1'b1);
    chk("coll_old_gain", 144'(gain_b_flat[143:126]), 144'd0);
    chk("coll_dirty", 144'(shadow_dirty), 144'd1);
    chk("coll_pulse", 144'(commit_pulse), 144'd1);
    step(1'b1, mk(4'hF, 1'b0, 3'd0, 4'h0, 20'h0), 1'b0);
    step(1'b1, mk(4'hF, 1'b0, 3'd0, 4'h0, 20'h0), 1'b1);
    chk("coll2_gain", 144'(gain_b_flat[143:126]), 144'h0AAA);
    chk("coll2_pending", 144'(commit_pending), 144'd1);
    chk("coll2_pulse", 144'(commit_pulse), 144'd1);
    idle(1'b1);
    chk("coll2_second_pulse", 144'(commit_pulse), 144'd1);
    chk("coll2_pending_clr", 144'(commit_pending), 144'd0);
    idle(1'b1);
    chk("coll2_pulse_end", 144'(commit_pulse), 144'd0);

    // Rejection
    step(1'b1, mk(4'h5, 1'b0, 3'd0, 4'h0, 20'h0), 1'b1);
    step(1'b1, mk(4'h1, 1'b0, 3'd1, 4'h1, 20'h001), 1'b1);
    step(1'b1, mk(4'h1, 1'b0, 3'd1, 4'h0, 20'h400), 1'b1);
    chk("rej_cnt", 144'(err_cnt), 144'd3);
    chk("rej_err", 144'(cmd_err), 144'd1);
    chk("rej_no_dirty", 144'(shadow_dirty), 144'd0);
    chk("rej_no_pending", 144'(commit_pending), 144'd0);
    step(1'b1, mk(4'h0, 1'b0, 3'd0, 4'h0, 20'h0), 1'b1);
    chk("clr_cnt", 144'(err_cnt), 144'd0);
    chk("clr_err", 144'(cmd_err), 144'd0);
    for (int i = 0; i < 300; i++)
      step(1'b1, mk(4'($urandom_range(3, 14)), 1'b0, 3'd0, 4'h0, 20'h0), 1'b0);
    chk("sat_cnt", 144'(err_cnt), 144'd255);
    step(1'b1, mk(4'h0, 1'b0, 3'd0, 4'h0, 20'h1), 1'b0);
    chk("sat_hold", 144'(err_cnt), 144'd255);
    step(1'b1, mk(4'h0, 1'b0, 3'd0, 4'h0, 20'h0), 1'b0);
    chk("sat_clr", 144'(err_cnt), 144'd0);

    // Random command stream
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 99));
      w = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: w[31:28] = 4'h1;
        3, 4, 5: w[31:28] = 4'h2;
        6:       w[31:28] = 4'hF;
        7:       w[31:28] = 4'h0;
        default: ;
      endcase
      if ($urandom_range(0, 3) != 0) w[23:20] = 4'h0;
      if ($urandom_range(0, 3) != 0) w[19:0] = w[31:28] == 4'h1 ? 20'(w[9:0]) : 20'(w[17:0]);
      if (w[31:28] == 4'h0 && $urandom_range(0, 1) == 0) w[19:0] = 20'h0;
      rst = (r == 0);
      step(r < 70, w, $urandom_range(0, 2) == 0);
    end
    rst = 1'b0;
    idle(1'b1);
    idle(1'b1);

    // Full sweep: 16 INDEX + 16 GAIN + COMMIT back-to-back
    for (int c = 0; c < 2; c++)
      for (int t = 0; t < 8; t++) begin
        sw_idx[c][t] = $urandom_range(0, 1023);
        step(1'b1, mk(4'h1, c[0], t[2:0], 4'h0, 20'(sw_idx[c][t])), 1'b0);
      end
    for (int c = 0; c < 2; c++)
      for (int t = 0; t < 8; t++) begin
        sw_gain[c][t] = $urandom_range(0, 262143);
        step(1'b1, mk(4'h2, c[0], t[2:0], 4'h0, 20'(sw_gain[c][t])), 1'b0);
      end
    step(1'b1, mk(4'hF, 1'b0, 3'd0, 4'h0, 20'h0), 1'b0);
    idle(1'b1);
    for (int t = 0; t < 8; t++) begin
      chk("sweep_idx_a", 144'(idx_a_flat[t*IDX_W +: IDX_W]), 144'(sw_idx[0][t]));
      chk("sweep_idx_b", 144'(idx_b_flat[t*IDX_W +: IDX_W]), 144'(sw_idx[1][t]));
      chk("sweep_gain_a", 144'(gain_a_flat[t*GAIN_W +: GAIN_W]), 144'(sw_gain[0][t]));
      chk("sweep_gain_b", 144'(gain_b_flat[t*GAIN_W +: GAIN_W]), 144'(sw_gain[1][t]));
    end

    // Reset while pending
    step(1'b1, mk(4'h5, 1'b0, 3'd0, 4'h0, 20'h0), 1'b0);
    step(1'b1, mk(4'hF, 1'b0, 3'd0, 4'h0, 20'h0), 1'b0);
    chk("rstp_pending", 144'(commit_pending), 144'd1);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    chk("rstp_idx", 144'({idx_a_flat, idx_b_flat}), 144'd0);
    chk("rstp_gain_a", 144'(gain_a_flat), 144'd0);
    chk("rstp_gain_b", 144'(gain_b_flat), 144'd0);
    chk("rstp_flags", 144'({commit_pulse, commit_pending, shadow_dirty, cmd_err}), 144'd0);
    chk("rstp_cnt", 144'(err_cnt), 144'd0);
    idle(1'b1);
    chk("rstp_no_pulse", 144'(commit_pulse), 144'd0);
    idle(1'b1);

    // Final report
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
